ps2_keyboard: RTL



---
 rtl/ps2_pkg.sv | 69 ++++++
 rtl/ps2_keyboard_if.sv | 10 +
 rtl/ps2_rx.sv | 142 ++++++++++++++
 rtl/ps2_keyboard.sv | 119 +++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types, scan-code constants and the set-2 to ASCII lookup for the PS/2 keyboard.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  // Set-2 make code to ASCII; 0x00 means unmapped. Shift uppercases letters and hides digits.
  function automatic logic [7:0] sc2ascii(input logic [7:0] code, input logic shift);
    logic [7:0] ch;
    ch = 8'h00;
    case (code)
      8'h1C: ch = 8'h61;  // a
      8'h32: ch = 8'h62;  // b
      8'h21: ch = 8'h63;  // c
      8'h23: ch = 8'h64;  // d
      8'h24: ch = 8'h65;  // e
      8'h2B: ch = 8'h66;  // f
      8'h34: ch = 8'h67;  // g
      8'h33: ch = 8'h68;  // h
      8'h43: ch = 8'h69;  // i
      8'h3B: ch = 8'h6A;  // j
      8'h42: ch = 8'h6B;  // k
      8'h4B: ch = 8'h6C;  // l
      8'h3A: ch = 8'h6D;  // m
      8'h31: ch = 8'h6E;  // n
      8'h44: ch = 8'h6F;  // o
      8'h4D: ch = 8'h70;  // p
      8'h15: ch = 8'h71;  // q
      8'h2D: ch = 8'h72;  // r
      8'h1B: ch = 8'h73;  // s
      8'h2C: ch = 8'h74;  // t
      8'h3C: ch = 8'h75;  // u
      8'h2A: ch = 8'h76;  // v
      8'h1D: ch = 8'h77;  // w
      8'h22: ch = 8'h78;  // x
      8'h35: ch = 8'h79;  // y
      8'h1A: ch = 8'h7A;  // z
      8'h45: ch = 8'h30;  // 0
      8'h16: ch = 8'h31;  // 1
      8'h1E: ch = 8'h32;  // 2
      8'h26: ch = 8'h33;  // 3
      8'h25: ch = 8'h34;  // 4
      8'h2E: ch = 8'h35;  // 5
      8'h36: ch = 8'h36;  // 6
      8'h3D: ch = 8'h37;  // 7
      8'h3E: ch = 8'h38;  // 8
      8'h46: ch = 8'h39;  // 9
      8'h29: ch = 8'h20;  // space
      8'h5A: ch = 8'h0D;  // enter
      8'h66: ch = 8'h08;  // backspace
      default: ch = 8'h00;
    endcase
    if (shift) begin
      if (ch >= 8'h61 && ch <= 8'h7A) ch = ch - 8'h20;
      else if (ch >= 8'h30 && ch <= 8'h39) ch = 8'h00;
    end
    return ch;
  endfunction

endpackage

// File: rtl/ps2_keyboard_if.sv
// Keyboard port towards the memory subsystem: head-of-FIFO key, pop level and status.
interface ps2_keyboard_if;
  logic       clean_key_buffer;
  logic [7:0] pressed_key;
  logic       frame_err;
  logic       overflow;

  modport master (output clean_key_buffer, input pressed_key, frame_err, overflow);
  modport slave  (input clean_key_buffer, output pressed_key, frame_err, overflow);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronizers, clock glitch filter, frame FSM and inter-bit timeout.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned TIMEOUT    = 24000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic [FW-1:0] flt_cnt;
  logic          clk_flt;
  logic          fall;
  logic          din;

  rx_state_t     state, state_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          par, par_nxt;
  logic [TW-1:0] to_cnt, to_cnt_nxt;
  logic [7:0]    code_nxt;
  logic          valid_nxt;
  logic          err_nxt;

  assign din = data_sync[1];

  // Two-flop synchronizers; reset to the released (high) bus level.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Accept a new clock level after FILTER_LEN differing samples; strobe on 1->0.
  always_ff @(posedge clk) begin
    if (rst) begin
      flt_cnt <= '0;
      clk_flt <= 1'b1;
      fall    <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_sync[1] == clk_flt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        flt_cnt <= '0;
        clk_flt <= clk_sync[1];
        fall    <= clk_flt;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  // Frame FSM state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      to_cnt     <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      par        <= par_nxt;
      to_cnt     <= to_cnt_nxt;
      code       <= code_nxt;
      code_valid <= valid_nxt;
      frame_err  <= err_nxt;
    end
  end

  // Next state: advance on each filtered falling edge, abandon the frame on timeout.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    par_nxt     = par;
    to_cnt_nxt  = '0;
    code_nxt    = code;
    valid_nxt   = 1'b0;
    err_nxt     = 1'b0;
    if (fall) begin
      case (state)
        IDLE: begin
          if (!din) begin
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
          end else begin
            err_nxt = 1'b1;
          end
        end
        DATA: begin
          shreg_nxt = {din, shreg[7:1]};
          if (bit_cnt == 3'd7) state_nxt = PARITY;
          else bit_cnt_nxt = bit_cnt + 3'd1;
        end
        PARITY: begin
          par_nxt   = din;
          state_nxt = STOP;
        end
        STOP: begin
          if (din && (^{shreg, par})) begin
            code_nxt  = shreg;
            valid_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end else if (state != IDLE) begin
      if (to_cnt == TW'(TIMEOUT - 1)) begin
        state_nxt = IDLE;
        err_nxt   = 1'b1;
      end else begin
        to_cnt_nxt = to_cnt + TW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard top: receiver, set-2 make/break decoder and ASCII key FIFO.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned TIMEOUT    = 24000
) (
  input  logic          CLK_CPU,
  input  logic          resetp,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  ps2_keyboard_if.slave kbd
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [7:0]    code;
  logic          code_valid;
  logic          rx_err;

  logic          ext, brk, shift;
  logic          ext_nxt, brk_nxt, shift_nxt;
  logic          push_c;
  logic [7:0]    ascii_c;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          clean_q;
  logic          overflow_q;
  logic          empty_c, full_c, pop_c, wr_c;

  ps2_rx #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) u_rx (
    .clk       (CLK_CPU),
    .rst       (resetp),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .code      (code),
    .code_valid(code_valid),
    .frame_err (rx_err)
  );

  assign ascii_c = sc2ascii(code, shift);

  // Decoder: track E0/F0 prefixes and shift, request a push for mapped make codes.
  always_comb begin
    ext_nxt   = ext;
    brk_nxt   = brk;
    shift_nxt = shift;
    push_c    = 1'b0;
    if (code_valid) begin
      if (code == SC_EXT) begin
        ext_nxt = 1'b1;
      end else if (code == SC_BREAK) begin
        brk_nxt = 1'b1;
      end else if (ext) begin
        ext_nxt = 1'b0;
        brk_nxt = 1'b0;
      end else if (brk) begin
        if (code == SC_LSHIFT || code == SC_RSHIFT) shift_nxt = 1'b0;
        brk_nxt = 1'b0;
      end else if (code == SC_LSHIFT || code == SC_RSHIFT) begin
        shift_nxt = 1'b1;
      end else begin
        push_c = (ascii_c != 8'h00);
      end
    end
  end

  // Decoder flag registers.
  always_ff @(posedge CLK_CPU) begin
    if (resetp) begin
      ext   <= 1'b0;
      brk   <= 1'b0;
      shift <= 1'b0;
    end else begin
      ext   <= ext_nxt;
      brk   <= brk_nxt;
      shift <= shift_nxt;
    end
  end

  assign empty_c = (count == '0);
  assign full_c  = (count == CW'(FIFO_DEPTH));
  assign pop_c   = kbd.clean_key_buffer & ~clean_q & ~empty_c;
  assign wr_c    = push_c & (~full_c | pop_c);

  // FIFO pointers, occupancy, pop edge detect and sticky overflow.
  always_ff @(posedge CLK_CPU) begin
    if (resetp) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      clean_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      clean_q <= kbd.clean_key_buffer;
      if (wr_c)  wr_ptr <= wr_ptr + PW'(1);
      if (pop_c) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(wr_c) - CW'(pop_c);
      if (push_c & full_c & ~pop_c) overflow_q <= 1'b1;
    end
  end

  // FIFO storage; contents are don't-care while the entry is unoccupied.
  always_ff @(posedge CLK_CPU) begin
    if (wr_c) mem[wr_ptr] <= ascii_c;
  end

  assign kbd.pressed_key = empty_c ? 8'h00 : mem[rd_ptr];
  assign kbd.frame_err   = rx_err;
  assign kbd.overflow    = overflow_q;

endmodule
